// File: rtl/deco_rr_arbiter_if.sv
// Bus between the requesters and deco_rr_arbiter.
// The requester side drives req/done. The arbiter side drives the decoder select/enable,
// the one-hot grant, busy and timeout.
interface deco_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] done;
  logic [2:0] grant_idx;
  logic       grant_en_n;
  logic [7:0] grant_oh;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant_idx,
    input  grant_en_n,
    input  grant_oh,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant_idx,
    output grant_en_n,
    output grant_oh,
    output busy,
    output timeout
  );
endinterface

// File: rtl/deco_rr_arbiter.sv
// deco_rr_arbiter: round-robin arbiter for one 8-way decoded resource.
// It drives the 3-to-8 decoder through grant_idx (A[2:0]) and grant_en_n (active-low enable).
// It also provides a registered one-hot grant for local use.
// Optional build macro: ARB_WATCHDOG_EN adds a hold counter that revokes a grant held MAX_HOLD cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; pick the next requester after ptr on any request
// S_GRANT | owner holds the decoder until done/req drop (or watchdog)
// S_GAP   | one dead turnaround cycle, decoder disabled, busy still high
module deco_rr_arbiter #(
  parameter int MAX_HOLD  = 16,
  parameter int RESET_PTR = 7
) (
  input logic             clk,
  input logic             reset,
  deco_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic       en_n_q, en_n_d;
  logic [7:0] oh_q, oh_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pick;
  logic [2:0] cand;
  logic       pick_vld;
  logic       owner_rel;
  logic       wd_hit;

  if (MAX_HOLD < 2) begin : g_max_hold_chk
    $error("deco_rr_arbiter: MAX_HOLD must be >= 2");
  end

  // Round-robin search: first requester at (ptr+1) upward, wrapping back to ptr itself last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!pick_vld && bus.req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Only the current owner's done/req bits can end its grant; every other bit is ignored.
  assign owner_rel = bus.done[idx_q] | ~bus.req[idx_q];

`ifdef ARB_WATCHDOG_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Last permitted GRANT cycle: releasing at this edge gives exactly MAX_HOLD cycles of grant.
  assign wd_hit = (state_q == S_GRANT) && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  // Hold counter: counts GRANT cycles, saturates, clears whenever GRANT is left.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == S_GRANT && state_d == S_GRANT) begin
      hold_cnt_d = (hold_cnt_q == HOLD_W'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  // Next-state and registered-output computation; a done on the limit cycle counts as normal release.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    en_n_d    = en_n_q;
    oh_d      = oh_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          idx_d   = pick;
          oh_d    = 8'h01 << pick;
          en_n_d  = 1'b0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (owner_rel || wd_hit) begin
          en_n_d    = 1'b1;
          oh_d      = '0;
          ptr_d     = idx_q;
          timeout_d = wd_hit & ~owner_rel;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        en_n_d  = 1'b1;
        oh_d    = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'(RESET_PTR);
      idx_q     <= '0;
      en_n_q    <= 1'b1;
      oh_q      <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      en_n_q    <= en_n_d;
      oh_q      <= oh_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant_idx  = idx_q;
  assign bus.grant_en_n = en_n_q;
  assign bus.grant_oh   = oh_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_deco_rr_arbiter.sv
// Bench for deco_rr_arbiter.
// Directed scenarios are followed by a randomized run checked against a cycle-level behavioural model.
module tb_deco_rr_arbiter;
  localparam int TB_MAX_HOLD  = 4;
  localparam int TB_RESET_PTR = 7;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  deco_rr_arbiter_if tif ();

  deco_rr_arbiter #(
    .MAX_HOLD  (TB_MAX_HOLD),
    .RESET_PTR (TB_RESET_PTR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who owns the resource, for how long, and where the search resumes.
  int m_owner;    // -1 when nobody holds the grant
  int m_gap;      // 1 during the dead cycle after a release
  int m_ptr;      // last released owner
  int m_last;     // last granted index (decoder select holds it)
  int m_cycles;   // cycles the current owner has seen the grant
  bit m_timeout;

  function automatic void model_reset();
    m_owner   = -1;
    m_gap     = 0;
    m_ptr     = TB_RESET_PTR;
    m_last    = 0;
    m_cycles  = 0;
    m_timeout = 1'b0;
  endfunction

  function automatic void model_step(logic [7:0] r, logic [7:0] d);
    bit normal;
    bit wd;
    m_timeout = 1'b0;
    if (m_owner >= 0) begin
      normal = d[m_owner] || !r[m_owner];
`ifdef ARB_WATCHDOG_EN
      wd = (m_cycles == TB_MAX_HOLD);
`else
      wd = 1'b0;
`endif
      if (normal || wd) begin
        m_ptr     = m_owner;
        m_owner   = -1;
        m_gap     = 1;
        m_timeout = wd && !normal;
      end else begin
        m_cycles++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (r != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
        end
      end
      m_last   = m_owner;
      m_cycles = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(tif.req, tif.done);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    tif.req  = 8'h00;
    tif.done = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (tif.grant_en_n !== 1'b1 || tif.grant_oh !== 8'h00 || tif.busy !== 1'b0 ||
        tif.grant_idx !== 3'd0 || tif.timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: en_n=%b oh=%h busy=%b idx=%0d timeout=%b, want 1 00 0 0 0",
               tif.grant_en_n, tif.grant_oh, tif.busy, tif.grant_idx, tif.timeout);
    end
    tif.req = 8'h08;
    tick();
    checks++;
    if (tif.grant_idx !== 3'd3 || tif.grant_en_n !== 1'b0 || tif.grant_oh !== 8'h08) begin
      errors++;
      $display("FAIL reset_pre_grant: idx=%0d en_n=%b oh=%h, want 3 0 08",
               tif.grant_idx, tif.grant_en_n, tif.grant_oh);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tif.grant_en_n !== 1'b1 || tif.grant_oh !== 8'h00 || tif.busy !== 1'b0 || tif.grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_async_drop: en_n=%b oh=%h busy=%b idx=%0d, want 1 00 0 0",
               tif.grant_en_n, tif.grant_oh, tif.busy, tif.grant_idx);
    end
    #2;
    reset   = 1'b0;
    model_reset();
    tif.req = 8'h01;
    tick();
    checks++;
    if (tif.grant_idx !== 3'd0 || tif.grant_en_n !== 1'b0 || tif.grant_oh !== 8'h01) begin
      errors++;
      $display("FAIL reset_after_release: idx=%0d en_n=%b oh=%h, want 0 0 01",
               tif.grant_idx, tif.grant_en_n, tif.grant_oh);
    end
  endtask

  task automatic test_basic();
    do_reset();
    tif.req = 8'b0000_0101;
    tick();
    checks++;
    if (tif.grant_idx !== 3'd0 || tif.grant_oh !== 8'h01 || tif.grant_en_n !== 1'b0 || tif.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first: idx=%0d oh=%h en_n=%b busy=%b, want 0 01 0 1",
               tif.grant_idx, tif.grant_oh, tif.grant_en_n, tif.busy);
    end
    tif.done = 8'h01;
    tick();
    tif.done = 8'h00;
    checks++;
    if (tif.grant_en_n !== 1'b1 || tif.grant_oh !== 8'h00 || tif.busy !== 1'b1 || tif.grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL basic_gap: en_n=%b oh=%h busy=%b idx=%0d, want 1 00 1 0",
               tif.grant_en_n, tif.grant_oh, tif.busy, tif.grant_idx);
    end
    tick();
    checks++;
    if (tif.grant_en_n !== 1'b1 || tif.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: en_n=%b busy=%b, want 1 0", tif.grant_en_n, tif.busy);
    end
    tick();
    checks++;
    if (tif.grant_idx !== 3'd2 || tif.grant_oh !== 8'h04 || tif.grant_en_n !== 1'b0) begin
      errors++;
      $display("FAIL basic_second: idx=%0d oh=%h en_n=%b, want 2 04 0",
               tif.grant_idx, tif.grant_oh, tif.grant_en_n);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tif.req = 8'h40;
    tick();
    tif.done = 8'h40;
    tick();
    tif.done = 8'h00;
    tif.req  = 8'b0100_0001;
    tick();
    tick();
    checks++;
    if (tif.grant_idx !== 3'd0 || tif.grant_oh !== 8'h01 || tif.grant_en_n !== 1'b0) begin
      errors++;
      $display("FAIL wrap_first: idx=%0d oh=%h en_n=%b, want 0 01 0",
               tif.grant_idx, tif.grant_oh, tif.grant_en_n);
    end
    tif.done = 8'h01;
    tick();
    tif.done = 8'h00;
    tick();
    tick();
    checks++;
    if (tif.grant_idx !== 3'd6 || tif.grant_oh !== 8'h40 || tif.grant_en_n !== 1'b0) begin
      errors++;
      $display("FAIL wrap_second: idx=%0d oh=%h en_n=%b, want 6 40 0",
               tif.grant_idx, tif.grant_oh, tif.grant_en_n);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    tif.req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (tif.grant_en_n !== 1'b0 || tif.grant_idx !== 3'(k % 8) || tif.grant_oh !== (8'h01 << (k % 8))) begin
        errors++;
        $display("FAIL fair_order[%0d]: idx=%0d oh=%h en_n=%b, want %0d",
                 k, tif.grant_idx, tif.grant_oh, tif.grant_en_n, k % 8);
      end
      tif.done = 8'h01 << (k % 8);
      tick();
      tif.done = 8'h00;
      checks++;
      if (tif.grant_en_n !== 1'b1 || tif.busy !== 1'b1) begin
        errors++;
        $display("FAIL fair_gap[%0d]: en_n=%b busy=%b, want 1 1", k, tif.grant_en_n, tif.busy);
      end
      tick();
      tick();
    end
    tif.req = 8'h00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_ignored_done();
    do_reset();
    tif.req = 8'h20;
    tick();
    tif.done = 8'b0000_0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (tif.grant_idx !== 3'd5 || tif.grant_en_n !== 1'b0 || tif.grant_oh !== 8'h20) begin
        errors++;
        $display("FAIL ignored_done[%0d]: idx=%0d en_n=%b oh=%h, want 5 0 20",
                 c, tif.grant_idx, tif.grant_en_n, tif.grant_oh);
      end
    end
    tif.done = 8'h00;
    tif.req  = 8'h00;
    tick();
    checks++;
    if (tif.grant_en_n !== 1'b1 || tif.grant_oh !== 8'h00 || tif.busy !== 1'b1) begin
      errors++;
      $display("FAIL req_drop_release: en_n=%b oh=%h busy=%b, want 1 00 1",
               tif.grant_en_n, tif.grant_oh, tif.busy);
    end
  endtask

  task automatic test_watchdog();
    int low;
    bit tseen;
    do_reset();
    tif.req = 8'h08;
    tick();
    low   = 1;
    tseen = 1'b0;
    for (int c = 0; c < 110; c++) begin
      tick();
      if (tif.timeout === 1'b1) tseen = 1'b1;
      if (tif.grant_en_n !== 1'b0) break;
      low++;
    end
`ifdef ARB_WATCHDOG_EN
    checks++;
    if (low != TB_MAX_HOLD) begin
      errors++;
      $display("FAIL wd_hold_len: held %0d cycles, want %0d", low, TB_MAX_HOLD);
    end
    checks++;
    if (tif.timeout !== 1'b1 || tif.busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_timeout_pulse: timeout=%b busy=%b, want 1 1", tif.timeout, tif.busy);
    end
    tick();
    checks++;
    if (tif.timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_timeout_width: timeout=%b, want 0", tif.timeout);
    end
`else
    checks++;
    if (low < 100 || tif.grant_idx !== 3'd3) begin
      errors++;
      $display("FAIL nowd_persist: held %0d cycles idx=%0d, want >=100 on 3", low, tif.grant_idx);
    end
    checks++;
    if (tseen !== 1'b0) begin
      errors++;
      $display("FAIL nowd_timeout: timeout seen=%b, want 0", tseen);
    end
`endif
    tif.req = 8'h00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] exp_oh;
    do_reset();
    r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) begin
        if (r[b]) begin
          if ($urandom_range(0, 9) == 0) r[b] = 1'b0;
        end else begin
          if ($urandom_range(0, 3) == 0) r[b] = 1'b1;
        end
      end
      tif.req  = r;
      tif.done = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      tick();
      exp_oh = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      checks++;
      if (tif.grant_en_n !== (m_owner < 0) || tif.grant_oh !== exp_oh ||
          tif.grant_idx !== 3'(m_last) || tif.busy !== (m_owner >= 0 || m_gap != 0) ||
          tif.timeout !== m_timeout) begin
        errors++;
        $display("FAIL random[%0d]: got idx=%0d en_n=%b oh=%h busy=%b to=%b, want idx=%0d en_n=%b oh=%h busy=%b to=%b",
                 c, tif.grant_idx, tif.grant_en_n, tif.grant_oh, tif.busy, tif.timeout,
                 m_last, (m_owner < 0), exp_oh, (m_owner >= 0 || m_gap != 0), m_timeout);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    tif.req  = 8'h00;
    tif.done = 8'h00;
    model_reset();
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_fairness();
    test_ignored_done();
    test_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
